uart_param_core: RTL



---
 rtl/uart_param_core.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART with runtime divisor, parity and stop-bit configuration.
module uart_param_core #(
  parameter int DATA_BITS = 8,
  parameter int OS        = 16,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_W-1:0]     baud_divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CW = $clog2(OS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               tx_state, tx_next;
  logic [DIV_W-1:0]     tx_div, tx_dcnt;
  logic [CW-1:0]        tx_os;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_pen, tx_pbit, tx_s2, tx_scnt;
  logic                 tx_tick, tx_bend, tx_last;

  assign tx_tick = tx_dcnt == tx_div - DIV_W'(1);
  assign tx_bend = tx_tick && tx_os == CW'(OS - 1);
  assign tx_last = tx_state == STOP && tx_bend && (!tx_s2 || tx_scnt);
  assign tx_done = tx_last;
  assign tx_busy = tx_state != IDLE;
  assign tx = tx_state == START ? 1'b0 :
              tx_state == DATA ? tx_sh[0] :
              tx_state == PARITY ? tx_pbit : 1'b1;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (tx_start) tx_next = START;
      START:   if (tx_bend) tx_next = DATA;
      DATA:    if (tx_bend && tx_bit == 4'(DATA_BITS - 1)) tx_next = tx_pen ? PARITY : STOP;
      PARITY:  if (tx_bend) tx_next = STOP;
      STOP:    if (tx_last) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_div   <= DIV_W'(1);
      tx_dcnt  <= '0;
      tx_os    <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_pen   <= 1'b0;
      tx_pbit  <= 1'b0;
      tx_s2    <= 1'b0;
      tx_scnt  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == IDLE) begin
        tx_dcnt <= '0;
        tx_os   <= '0;
        tx_bit  <= '0;
        tx_scnt <= 1'b0;
        if (tx_start) begin
          tx_div  <= baud_divisor == '0 ? DIV_W'(1) : baud_divisor;
          tx_sh   <= tx_data;
          tx_pen  <= parity_mode[0] ^ parity_mode[1];
          tx_pbit <= (^tx_data) ^ (parity_mode == 2'b10);
          tx_s2   <= stop2;
        end
      end else begin
        tx_dcnt <= tx_tick ? '0 : tx_dcnt + DIV_W'(1);
        if (tx_tick) tx_os <= tx_bend ? '0 : tx_os + CW'(1);
        if (tx_bend && tx_state == DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_bit <= tx_bit + 4'd1;
        end
        if (tx_bend && tx_state == STOP) tx_scnt <= 1'b1;
      end
    end
  end

  // Synchroniser keeps tracking the line through reset so a line already low is not seen as a new start.
  logic rx_s1, rx_s2, rx_s3;
  always_ff @(posedge clk) begin
    rx_s1 <= rx;
    rx_s2 <= rx_s1;
    rx_s3 <= rx_s2;
  end

  state_t               rx_state, rx_next;
  logic [DIV_W-1:0]     rx_div, rx_dcnt;
  logic [CW-1:0]        rx_os;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic [1:0]           rx_smp;
  logic                 rx_pen, rx_odd, rx_perr;
  logic                 rx_fall, rx_tick, rx_bend, rx_mid, rx_late, rx_maj, rx_done;

  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_tick = rx_dcnt == rx_div - DIV_W'(1);
  assign rx_bend = rx_tick && rx_os == CW'(OS - 1);
  assign rx_mid  = rx_tick && rx_os == CW'(OS / 2 - 1);
  assign rx_late = rx_tick && rx_os == CW'(OS / 2);
  assign rx_maj  = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_s2) | (rx_smp[1] & rx_s2);
  assign rx_done = rx_state == STOP && rx_mid;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_fall) rx_next = START;
      START:   rx_next = rx_mid && rx_s2 ? IDLE : rx_bend ? DATA : START;
      DATA:    if (rx_bend && rx_bit == 4'(DATA_BITS - 1)) rx_next = rx_pen ? PARITY : STOP;
      PARITY:  if (rx_bend) rx_next = STOP;
      STOP:    if (rx_mid) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state      <= IDLE;
      rx_div        <= DIV_W'(1);
      rx_dcnt       <= '0;
      rx_os         <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_smp        <= '0;
      rx_pen        <= 1'b0;
      rx_odd        <= 1'b0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      rx_overrun <= 1'b0;
      if (rx_state == IDLE) begin
        rx_dcnt <= '0;
        rx_os   <= '0;
        rx_bit  <= '0;
        rx_perr <= 1'b0;
        if (rx_fall) begin
          rx_div <= baud_divisor == '0 ? DIV_W'(1) : baud_divisor;
          rx_pen <= parity_mode[0] ^ parity_mode[1];
          rx_odd <= parity_mode == 2'b10;
        end
      end else begin
        rx_dcnt <= rx_tick ? '0 : rx_dcnt + DIV_W'(1);
        if (rx_tick) rx_os <= rx_bend ? '0 : rx_os + CW'(1);
        if (rx_tick && (rx_os == CW'(OS / 2 - 2) || rx_os == CW'(OS / 2 - 1))) rx_smp <= {rx_smp[0], rx_s2};
        if (rx_late && rx_state == DATA) rx_sh <= {rx_maj, rx_sh[DATA_BITS-1:1]};
        if (rx_late && rx_state == PARITY) rx_perr <= rx_maj ^ (^rx_sh) ^ rx_odd;
        if (rx_bend && rx_state == DATA) rx_bit <= rx_bit + 4'd1;
      end
      if (rx_done && (!rx_valid || rx_ack)) begin
        rx_data       <= rx_sh;
        rx_parity_err <= rx_perr;
        rx_frame_err  <= ~rx_s2;
        rx_valid      <= 1'b1;
      end else if (rx_done) begin
        rx_overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule
